pipe_reg_file: RTL and testbench
================================

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, giving 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4, number of read ports.
REQ-004 SHALL have parameter SP_INIT, default `STAK_ADDRESS, x2 reset value.
REQ-005 SHALL have parameter GP_INIT, default `MMIO_ADDRESS, x3 reset value.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits, packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data, output, NUM_RD*DATA_W bits, packed read data.
REQ-010 SHALL have port rd_busy, output, NUM_RD bits, scoreboard pending flag per read port.
REQ-011 SHALL have port wr_en, input, 1 bit, writeback strobe.
REQ-012 SHALL have port wr_addr, input, ADDR_W bits, writeback register.
REQ-013 SHALL have port wr_data, input, DATA_W bits, writeback data.
REQ-014 SHALL have port issue_en, input, 1 bit, marks issue_addr pending.
REQ-015 SHALL have port issue_addr, input, ADDR_W bits, destination of issued instruction.
REQ-016 SHALL have port flush, input, 1 bit, clears all pending bits.
REQ-017 SHALL have port busy_vec, output, 2**ADDR_W bits, pending bit per register.
REQ-018 SHALL have port any_busy, output, 1 bit, OR of busy_vec.

Function
REQ-019 Register 0 SHALL read 0 and be unwritable; its pending bit SHALL stay 0 (issue/write to x0 ignored).
REQ-020 Write: wr_en=1 and wr_addr!=0 SHALL store wr_data into wr_addr at the clock edge.
REQ-021 Read: rd_data[k] SHALL be combinational, zero latency, from rd_addr[k]; all ports independent, identical addresses allowed.
REQ-022 Scoreboard: issue_en=1 SHALL set busy_vec[issue_addr] at the edge; wr_en=1 SHALL clear busy_vec[wr_addr] at the edge.
REQ-023 Simultaneous issue and writeback to the same register SHALL leave the bit set (new producer wins); to different registers, both updates SHALL apply.
REQ-024 flush=1 SHALL clear every pending bit at the edge, overriding issue_en in that cycle; register contents SHALL be unaffected; a concurrent wr_en SHALL still write.
REQ-025 rd_busy[k] SHALL equal busy_vec[rd_addr[k]] registered state, except as modified by REQ-030.
REQ-026 Writeback to a non-pending register SHALL write normally and leave the bit 0.
REQ-027 any_busy SHALL be combinational from current busy_vec.

Reset
REQ-028 reset=0 SHALL asynchronously set x2=SP_INIT, x3=GP_INIT, all other registers 0, busy_vec=0, independent of clk.
REQ-029 While reset=0, wr_en/issue_en/flush SHALL be ignored; first update occurs on the first rising edge after reset deasserts; outputs during reset reflect reset state (rd_data per addresses, rd_busy=0, any_busy=0).

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and rd_addr[k]==wr_addr, rd_data[k] SHALL be wr_data and rd_busy[k] SHALL be 0 in the same cycle (write-through).
REQ-031 Macro REGFILE_BYPASS_EN undefined: rd_data[k] SHALL return stored contents (new value visible next cycle) and rd_busy[k] SHALL reflect stored pending bit.

Verification
REQ-032 Release reset, read x2,x3,x5 -> SP_INIT, GP_INIT, 0; assert reset mid-write of x5=0xDEAD -> x5 reads 0 immediately.
REQ-033 wr_en x0=0xFFFF_FFFF, issue_en x0 -> x0 reads 0, busy_vec[0]=0.
REQ-034 issue x7; next cycle rd_addr0=7 -> rd_busy0=1, any_busy=1; wr x7=0x1234 -> following cycle rd_data0=0x1234, rd_busy0=0, any_busy=0.
REQ-035 Same-cycle issue x9 and wr x9=0x55 -> x9=0x55, busy_vec[9]=1; issue x4,x6 then flush with issue x8 -> busy_vec=0.
REQ-036 wr x10=0xCAFE with rd_addr1=10 same cycle -> rd_data1=0xCAFE with REGFILE_BYPASS_EN, old value without; next cycle 0xCAFE in both builds.
REQ-037 Rerun REQ-032..036 with DATA_W=64, ADDR_W=4, NUM_RD=4 -> identical behaviour, 16 busy bits.

Source files
------------

// File: rtl/pipe_reg_file.sv
// pipe_reg_file: multi-read-port register file with per-register scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
`ifndef STAK_ADDRESS
`define STAK_ADDRESS 32'h0000_3FF0
`endif
`ifndef MMIO_ADDRESS
`define MMIO_ADDRESS 32'h0000_8000
`endif

module pipe_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(`STAK_ADDRESS),
    parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(`MMIO_ADDRESS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [2**ADDR_W-1:0]     busy_vec,
    output logic                     any_busy
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wr_ok;

    assign wr_ok = wr_en && (wr_addr != '0);

    // Issue is applied after writeback clear so a new producer wins; flush beats both.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) regs_d[wr_addr] = wr_data;
        if (wr_en) busy_d[wr_addr] = 1'b0;
        if (issue_en) busy_d[issue_addr] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            regs_q[2] <= SP_INIT;
            regs_q[3] <= GP_INIT;
            busy_q    <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign any_busy = |busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        // Writes are ignored during reset, so the bypass must be too.
        assign hit = reset && wr_ok && (a == wr_addr);
        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs_q[a];
        assign rd_busy[k] = !hit && busy_q[a];
`else
        assign rd_data[k*DATA_W +: DATA_W] = regs_q[a];
        assign rd_busy[k] = busy_q[a];
`endif
    end
endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed checks on a 32x32/2-port and a 16x64/4-port
// instance driven by the same stimulus.
module tb_pipe_reg_file;
    localparam logic [63:0] SP = 64'h0000_0000_7FFF_FFF0;
    localparam logic [63:0] GP = 64'h0000_0000_1000_8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0, issue_en = 1'b0, flush = 1'b0;
    logic [4:0]  wa = '0, ia = '0;
    logic [63:0] wd = '0;
    logic [4:0]  ra [4];

    logic [9:0]   rd_addr_a;
    logic [63:0]  rd_data_a;
    logic [1:0]   rd_busy_a;
    logic [31:0]  busy_a;
    logic         any_a;
    logic [15:0]  rd_addr_b;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic [15:0]  busy_b;
    logic         any_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rd_addr_a = {ra[1], ra[0]};
    assign rd_addr_b = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

    pipe_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                    .SP_INIT(SP[31:0]), .GP_INIT(GP[31:0])) u_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd[31:0]),
        .issue_en(issue_en), .issue_addr(ia), .flush(flush),
        .busy_vec(busy_a), .any_busy(any_a));

    pipe_reg_file #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4),
                    .SP_INIT(SP), .GP_INIT(GP)) u_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wa[3:0]), .wr_data(wd),
        .issue_en(issue_en), .issue_addr(ia[3:0]), .flush(flush),
        .busy_vec(busy_b), .any_busy(any_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int k, input logic [63:0] exp);
        if (k < 2) check({tag, "_a"}, {32'h0, rd_data_a[k*32 +: 32]}, {32'h0, exp[31:0]});
        check({tag, "_b"}, rd_data_b[k*64 +: 64], exp);
    endtask

    task automatic chk_rb(input string tag, input int k, input logic exp);
        if (k < 2) check({tag, "_a"}, {63'h0, rd_busy_a[k]}, {63'h0, exp});
        check({tag, "_b"}, {63'h0, rd_busy_b[k]}, {63'h0, exp});
    endtask

    task automatic chk_bv(input string tag, input logic [15:0] exp);
        check({tag, "_vec_a"}, {32'h0, busy_a}, {48'h0, exp});
        check({tag, "_vec_b"}, {48'h0, busy_b}, {48'h0, exp});
        check({tag, "_any_a"}, {63'h0, any_a}, {63'h0, |exp});
        check({tag, "_any_b"}, {63'h0, any_b}, {63'h0, |exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_byp;
        logic        exp_bb;
        for (int i = 0; i < 4; i++) ra[i] = '0;
        #1 reset = 1'b0;
        ra[0] = 5'd2; ra[1] = 5'd3; ra[2] = 5'd5; ra[3] = 5'd0;
        wr_en = 1'b1; wa = 5'd5; wd = 64'hDEAD; issue_en = 1'b1; ia = 5'd5;
        #2;
        chk_rd("rst_x2", 0, SP);
        chk_rd("rst_x3", 1, GP);
        chk_rd("rst_x5_byp", 2, 64'h0);
        chk_rb("rst_rb0", 0, 1'b0);
        tick;
        chk_rd("rst_ign_x5", 2, 64'h0);
        chk_bv("rst_ign", 16'h0);
        @(negedge clk);
        idle;
        reset = 1'b1;
        #1;
        chk_rd("rel_x2", 0, SP);
        chk_rd("rel_x3", 1, GP);
        chk_rd("rel_x5", 2, 64'h0);

        wr_en = 1'b1; wa = 5'd2; wd = 64'h77;
        tick;
        chk_rd("wr_x2", 0, 64'h77);
        wa = 5'd5; wd = 64'hDEAD;
        tick;
        chk_rd("wr_x5", 2, 64'hDEAD);
        #2 reset = 1'b0;
        #1;
        chk_rd("arst_x5", 2, 64'h0);
        chk_rd("arst_x2", 0, SP);
        @(negedge clk);
        idle;
        reset = 1'b1;

        wr_en = 1'b1; wa = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF; issue_en = 1'b1; ia = 5'd0;
        tick;
        idle;
        ra[0] = 5'd0;
        #1;
        chk_rd("x0_zero", 0, 64'h0);
        chk_bv("x0_busy", 16'h0);

        issue_en = 1'b1; ia = 5'd7;
        tick;
        idle;
        ra[0] = 5'd7;
        #1;
        chk_rb("iss7_rb0", 0, 1'b1);
        chk_bv("iss7", 16'h0080);
        wr_en = 1'b1; wa = 5'd7; wd = 64'h1234;
        tick;
        idle;
        #1;
        chk_rd("wb7_data", 0, 64'h1234);
        chk_rb("wb7_rb0", 0, 1'b0);
        chk_bv("wb7", 16'h0);

        issue_en = 1'b1; ia = 5'd9; wr_en = 1'b1; wa = 5'd9; wd = 64'h55;
        tick;
        idle;
        ra[0] = 5'd9;
        #1;
        chk_rd("same9_data", 0, 64'h55);
        chk_rb("same9_rb0", 0, 1'b1);
        chk_bv("same9", 16'h0200);
        issue_en = 1'b1; ia = 5'd4; wr_en = 1'b1; wa = 5'd9; wd = 64'h66;
        tick;
        chk_bv("diff", 16'h0010);
        wr_en = 1'b0; ia = 5'd6;
        tick;
        chk_bv("iss6", 16'h0050);
        flush = 1'b1; issue_en = 1'b1; ia = 5'd8; wr_en = 1'b1; wa = 5'd11; wd = 64'hAB;
        tick;
        idle;
        ra[0] = 5'd11; ra[1] = 5'd9; ra[2] = 5'd8;
        #1;
        chk_bv("flush", 16'h0);
        chk_rd("flush_wr11", 0, 64'hAB);
        chk_rd("flush_x9", 1, 64'h66);

        issue_en = 1'b1; ia = 5'd10;
        tick;
        idle;
        ra[0] = 5'd10; ra[1] = 5'd10; ra[3] = 5'd10;
        wr_en = 1'b1; wa = 5'd10; wd = 64'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 64'hCAFE;
        exp_bb  = 1'b0;
`else
        exp_byp = 64'h0;
        exp_bb  = 1'b1;
`endif
        chk_rd("byp_rd1", 1, exp_byp);
        chk_rd("byp_rd3", 3, exp_byp);
        chk_rb("byp_rb1", 1, exp_bb);
        tick;
        idle;
        #1;
        chk_rd("post_rd0", 0, 64'hCAFE);
        chk_rd("post_rd1", 1, 64'hCAFE);
        chk_rb("post_rb1", 1, 1'b0);
        chk_bv("post", 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
